// File: rtl/alu_operand_stage.sv
// ID/EX operand stage feeding the 32-bit ALU: resolves forwarding, extends the
// immediate and registers operands/control behind a one-entry valid/ready slot.
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [IMM_W-1:0]  imm,
  input  logic              imm_zext,
  input  logic              alu_src,
  input  logic [1:0]        alu_ctrl_in,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              reg_write_in,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] operand1,
  output logic [DATA_W-1:0] operand2,
  output logic [1:0]        alu_control,
  output logic [DATA_W-1:0] store_data,
  output logic [REG_AW-1:0] rd_out,
  output logic              reg_write_out
);

  logic              capture;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic [DATA_W-1:0] imm_ext;

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // EX/MEM is the younger producer, so it wins over MEM/WB; $zero never forwards.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    rs_fwd  = rs_data;
    rt_fwd  = rt_data;
    imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm};

    if (exmem_reg_write && exmem_rd == rs_addr && rs_addr != '0)
      rs_fwd = exmem_result;
    else if (memwb_reg_write && memwb_rd == rs_addr && rs_addr != '0)
      rs_fwd = memwb_result;

    if (exmem_reg_write && exmem_rd == rt_addr && rt_addr != '0)
      rt_fwd = exmem_result;
    else if (memwb_reg_write && memwb_rd == rt_addr && rt_addr != '0)
      rt_fwd = memwb_result;

    if (!imm_zext)
      imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slot is a handful of flops, so every field is reset, not just out_valid.
      out_valid     <= 1'b0;
      reg_write_out <= 1'b0;
      operand1      <= '0;
      operand2      <= '0;
      alu_control   <= 2'b00;
      store_data    <= '0;
      rd_out        <= '0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      reg_write_out <= 1'b0;
    end else if (capture) begin
      out_valid     <= 1'b1;
      reg_write_out <= reg_write_in;
      operand1      <= rs_fwd;
      operand2      <= alu_src ? imm_ext : rt_fwd;
      alu_control   <= alu_ctrl_in;
      store_data    <= rt_fwd;
      rd_out        <= rd_addr;
    end else if (out_valid && out_ready) begin
      // Drained: data fields keep their last values, only the live bits drop.
      out_valid     <= 1'b0;
      reg_write_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed vector table, hand-written
// stall/flush/reset sequences, and random traffic against a behavioural model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  rs_addr, rt_addr, rd_addr, exmem_rd, memwb_rd, rd_out;
  logic [31:0] rs_data, rt_data, exmem_result, memwb_result;
  logic [15:0] imm;
  logic        imm_zext, alu_src, reg_write_in, exmem_reg_write, memwb_reg_write;
  logic [1:0]  alu_ctrl_in, alu_control;
  logic        flush, out_ready, out_valid, reg_write_out;
  logic [31:0] operand1, operand2, store_data;

  int n_checks = 0;
  int n_fail   = 0;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .imm(imm), .imm_zext(imm_zext), .alu_src(alu_src), .alu_ctrl_in(alu_ctrl_in),
    .rd_addr(rd_addr), .reg_write_in(reg_write_in),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .operand1(operand1), .operand2(operand2), .alu_control(alu_control),
    .store_data(store_data), .rd_out(rd_out), .reg_write_out(reg_write_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  rs_a, rt_a;
    logic [31:0] rs_d, rt_d;
    logic [15:0] imm;
    logic        zext, src;
    logic [1:0]  ctrl;
    logic        ex_we;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic [31:0] e_op1, e_op2, e_st;
  } vec_t;

  vec_t vecs[8];

  // Behavioural reference state: the instruction the ALU should currently see.
  logic        m_valid, m_rw;
  logic [31:0] m_op1, m_op2, m_st;
  logic [1:0]  m_ctrl;
  logic [4:0]  m_rd;

  function automatic logic [31:0] ref_src(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return rf;
    if (exmem_reg_write && exmem_rd == a) return exmem_result;
    if (memwb_reg_write && memwb_rd == a) return memwb_result;
    return rf;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [15:0] i, input logic z);
    logic [31:0] v;
    v = {16'h0, i};
    if (!z && i >= 16'h8000) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; rs_addr = 0; rt_addr = 0; rs_data = 0; rt_data = 0; imm = 0;
    imm_zext = 0; alu_src = 0; alu_ctrl_in = 0; rd_addr = 0; reg_write_in = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0; flush = 0; out_ready = 1;
  endtask

  task automatic drive_simple(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    in_valid = 1; rs_addr = 5'd1; rt_addr = 5'd2; rs_data = a; rt_data = b;
    alu_src = 0; alu_ctrl_in = 2'b10; rd_addr = rd; reg_write_in = 1;
    exmem_reg_write = 0; memwb_reg_write = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    #12;
    check("reset out_valid", {31'b0, out_valid}, 0);
    check("reset operand1", operand1, 0);
    check("reset operand2", operand2, 0);
    check("reset alu_control", {30'b0, alu_control}, 0);
    check("reset reg_write_out", {31'b0, reg_write_out}, 0);
    check("reset in_ready", {31'b0, in_ready}, 1);
    @(negedge clk);
    rst_n = 1;

    // rs, rt, rs_d, rt_d, imm, zext, src, ctrl, ex_we, ex_rd, ex_res, wb_we, wb_rd, wb_res, op1, op2, st
    vecs[0] = '{5'd1, 5'd2, 32'd85, 32'd16554, 16'h0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd0, 32'd0,
                1'b0, 5'd0, 32'd0, 32'd85, 32'd16554, 32'd16554};
    vecs[1] = '{5'd1, 5'd2, 32'd3, 32'd44, 16'hFFFF, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 32'd0,
                1'b0, 5'd0, 32'd0, 32'd3, 32'hFFFF_FFFF, 32'd44};
    vecs[2] = '{5'd1, 5'd2, 32'd3, 32'd44, 16'hFFFF, 1'b1, 1'b1, 2'b01, 1'b0, 5'd0, 32'd0,
                1'b0, 5'd0, 32'd0, 32'd3, 32'h0000_FFFF, 32'd44};
    vecs[3] = '{5'd1, 5'd2, 32'd3, 32'd44, 16'h7FFF, 1'b0, 1'b1, 2'b11, 1'b0, 5'd0, 32'd0,
                1'b0, 5'd0, 32'd0, 32'd3, 32'h0000_7FFF, 32'd44};
    vecs[4] = '{5'd8, 5'd8, 32'd100, 32'd100, 16'h0, 1'b0, 1'b0, 2'b10, 1'b1, 5'd8, 32'd7,
                1'b1, 5'd8, 32'd9, 32'd7, 32'd7, 32'd7};
    vecs[5] = '{5'd8, 5'd8, 32'd100, 32'd100, 16'h0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd8, 32'd7,
                1'b1, 5'd8, 32'd9, 32'd9, 32'd9, 32'd9};
    vecs[6] = '{5'd0, 5'd0, 32'h1234, 32'h0, 16'h0, 1'b0, 1'b0, 2'b10, 1'b1, 5'd0, 32'd5,
                1'b1, 5'd0, 32'd6, 32'h1234, 32'h0, 32'h0};
    vecs[7] = '{5'd3, 5'd4, 32'd1, 32'd2, 16'h8000, 1'b0, 1'b1, 2'b11, 1'b1, 5'd4, 32'hAA,
                1'b1, 5'd3, 32'hBB, 32'hBB, 32'hFFFF_8000, 32'hAA};

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1; out_ready = 1; flush = 0;
      rs_addr = vecs[i].rs_a; rt_addr = vecs[i].rt_a;
      rs_data = vecs[i].rs_d; rt_data = vecs[i].rt_d;
      imm = vecs[i].imm; imm_zext = vecs[i].zext; alu_src = vecs[i].src;
      alu_ctrl_in = vecs[i].ctrl; rd_addr = 5'(i + 10); reg_write_in = 1;
      exmem_reg_write = vecs[i].ex_we; exmem_rd = vecs[i].ex_rd; exmem_result = vecs[i].ex_res;
      memwb_reg_write = vecs[i].wb_we; memwb_rd = vecs[i].wb_rd; memwb_result = vecs[i].wb_res;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 1);
      check($sformatf("vec%0d operand1", i), operand1, vecs[i].e_op1);
      check($sformatf("vec%0d operand2", i), operand2, vecs[i].e_op2);
      check($sformatf("vec%0d store_data", i), store_data, vecs[i].e_st);
      check($sformatf("vec%0d alu_control", i), {30'b0, alu_control}, {30'b0, vecs[i].ctrl});
      check($sformatf("vec%0d rd_out", i), {27'b0, rd_out}, 32'(i + 10));
    end
    in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    check("drain out_valid", {31'b0, out_valid}, 0);
    check("drain reg_write_out", {31'b0, reg_write_out}, 0);
    check("drain data holds", operand1, 32'hBB);

    // Stall: A held for 3 cycles while B waits, then B enters on the release edge.
    drive_simple(32'hA1, 32'hA2, 5'd5);
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    drive_simple(32'hB1, 32'hB2, 5'd6);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d in_ready", c), {31'b0, in_ready}, 0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("stall%0d out_valid", c), {31'b0, out_valid}, 1);
      check($sformatf("stall%0d operand1", c), operand1, 32'hA1);
      check($sformatf("stall%0d rd_out", c), {27'b0, rd_out}, 5);
    end
    out_ready = 1;
    #1;
    check("release in_ready", {31'b0, in_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    check("release B captured", operand1, 32'hB1);
    check("release B valid", {31'b0, out_valid}, 1);
    in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    check("no duplicate out_valid", {31'b0, out_valid}, 0);

    // Flush while a live instruction is stalled, with a new one offered.
    drive_simple(32'hC1, 32'hC2, 5'd7);
    @(posedge clk);
    @(negedge clk);
    out_ready = 0; flush = 1;
    drive_simple(32'hD1, 32'hD2, 5'd8);
    @(posedge clk);
    @(negedge clk);
    check("flush out_valid", {31'b0, out_valid}, 0);
    check("flush reg_write_out", {31'b0, reg_write_out}, 0);
    // Flush beats a capture that would otherwise be accepted.
    out_ready = 1;
    #1;
    check("flush in_ready", {31'b0, in_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    check("flush drops incoming", {31'b0, out_valid}, 0);
    flush = 0;

    // Asynchronous reset in the middle of a stall.
    drive_simple(32'hE1, 32'hE2, 5'd9);
    @(posedge clk);
    @(negedge clk);
    out_ready = 0; in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    check("async rst out_valid", {31'b0, out_valid}, 0);
    check("async rst operand1", operand1, 0);
    check("async rst store_data", store_data, 0);
    check("async rst reg_write_out", {31'b0, reg_write_out}, 0);
    check("async rst rd_out", {27'b0, rd_out}, 0);
    @(negedge clk);
    rst_n = 1;

    // Random traffic against the behavioural model.
    do_reset();
    m_valid = 0; m_rw = 0; m_op1 = 0; m_op2 = 0; m_st = 0; m_ctrl = 0; m_rd = 0;
    for (int n = 0; n < 400; n++) begin
      logic exp_ready, acc;
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = 1'($urandom_range(0, 15) == 0);
      rs_addr = 5'($urandom_range(0, 3)); rt_addr = 5'($urandom_range(0, 3));
      rs_data = $urandom; rt_data = $urandom; imm = 16'($urandom);
      imm_zext = 1'($urandom); alu_src = 1'($urandom); alu_ctrl_in = 2'($urandom);
      rd_addr = 5'($urandom); reg_write_in = 1'($urandom);
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
      exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
      memwb_result = $urandom;
      #1;
      exp_ready = !m_valid || out_ready;
      check("rand in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      acc = in_valid && exp_ready && !flush;
      if (flush) begin
        m_valid = 0; m_rw = 0;
      end else if (acc) begin
        m_valid = 1; m_rw = reg_write_in;
        m_op1 = ref_src(rs_addr, rs_data);
        m_st = ref_src(rt_addr, rt_data);
        m_op2 = alu_src ? ref_imm(imm, imm_zext) : m_st;
        m_ctrl = alu_ctrl_in; m_rd = rd_addr;
      end else if (m_valid && out_ready) begin
        m_valid = 0; m_rw = 0;
      end
      @(posedge clk);
      @(negedge clk);
      check("rand out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      check("rand reg_write_out", {31'b0, reg_write_out}, {31'b0, m_rw});
      check("rand operand1", operand1, m_op1);
      check("rand operand2", operand2, m_op2);
      check("rand store_data", store_data, m_st);
      check("rand alu_control", {30'b0, alu_control}, {30'b0, m_ctrl});
      check("rand rd_out", {27'b0, rd_out}, {27'b0, m_rd});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
